fifo_drain_ctrl: RTL and testbench



---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_skid_buf.sv | 63 ++++++
 rtl/fifo_drain_ctrl.sv | 75 +++++++
 tb/tb_fifo_drain_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// ============================================================================
// fifo_pkg : shared widths for the 64 x 16 FIFO and its read-side controller
// Revision : 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

  localparam int DATA_W     = 16;
  localparam int FIFO_DEPTH = 64;

  // Counter width that stays legal when the count range collapses to one value
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_skid_buf.sv
// ============================================================================
// fifo_skid_buf : 2-entry register skid buffer with push/pop/flush and occupancy
// Revision      : 1.0
// ============================================================================
`default_nettype none

module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       occ,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [1:0]       r_occ;

  assign occ       = r_occ;
  assign head_data = r_head;

  // Callers guarantee no push into a full buffer and no pop from an empty one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= 2'd0;
    end else if (flush) begin
      r_occ <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (r_occ == 2'd0) r_head <= push_data;
          else               r_tail <= push_data;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_head <= r_tail;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_head <= push_data;
          end else begin
            r_head <= r_tail;
            r_tail <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_drain_ctrl.sv
// ============================================================================
// fifo_drain_ctrl : FIFO read-side controller presenting a valid/ready stream
//                   with fixed-length burst marking on out_last
// Revision        : 1.0
// ============================================================================
`default_nettype none

module fifo_drain_ctrl #(
  parameter int DATA_W    = fifo_pkg::DATA_W,
  parameter int BURST_LEN = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [DATA_W-1:0] buf_out,
  input  logic              buf_empty,
  output logic              rd_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  import fifo_pkg::*;

  localparam int              BEAT_W     = cnt_width(BURST_LEN);
  localparam logic [BEAT_W-1:0] C_BEAT_MAX = BEAT_W'(BURST_LEN - 1);

  logic              r_inflight;
  logic [BEAT_W-1:0] r_beat;
  logic [1:0]        w_occ;
  logic [DATA_W-1:0] w_head;
  logic              w_pop;
  logic              w_capture;
  logic [2:0]        w_level;

  assign out_valid = (w_occ != 2'd0);
  assign out_data  = w_head;
  assign out_last  = out_valid && (r_beat == C_BEAT_MAX);
  assign w_pop     = out_valid && out_ready;
  assign w_capture = r_inflight && !clr;

  // Entries committed after this edge; counting the pop keeps 1 word/cycle flowing
  assign w_level = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign rd_en   = rst_n && !buf_empty && !clr && (w_level < 3'd2);

  fifo_skid_buf #(
    .WIDTH (DATA_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (clr),
    .push      (w_capture),
    .push_data (buf_out),
    .pop       (w_pop),
    .occ       (w_occ),
    .head_data (w_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_beat     <= '0;
    end else begin
      r_inflight <= rd_en;
      if (clr)
        r_beat <= '0;
      else if (w_pop)
        r_beat <= (r_beat == C_BEAT_MAX) ? '0 : r_beat + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_drain_ctrl.sv
// ============================================================================
// tb_fifo_drain_ctrl : scoreboard bench with a behavioural FIFO and stream model
// Revision           : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fifo_drain_ctrl;

  localparam int DATA_W    = 16;
  localparam int BURST_LEN = 8;
  localparam int DEPTH     = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clr = 1'b0;
  logic [DATA_W-1:0] buf_out = '0;
  logic              buf_empty = 1'b1;
  logic              out_ready = 1'b0;
  logic              rd_en;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_last;

  fifo_drain_ctrl #(
    .DATA_W    (DATA_W),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .buf_out   (buf_out),
    .buf_empty (buf_empty),
    .rd_en     (rd_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [DATA_W-1:0] fifo_q[$];
  logic [DATA_W-1:0] wr_q[$];
  logic [DATA_W-1:0] exp_q[$];
  int reads = 0;
  int delivered = 0;
  int since_clr = 0;
  int cyc = 0;
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  logic              prev_last = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Behavioural FIFO: registered read data, writes land at the next edge
  always @(posedge clk) begin
    cyc++;
    if (rd_en && fifo_q.size() > 0) begin
      buf_out <= fifo_q.pop_front();
      reads++;
    end
    while (wr_q.size() > 0 && fifo_q.size() < DEPTH)
      fifo_q.push_back(wr_q.pop_front());
    buf_empty <= (fifo_q.size() == 0);
  end

  // Monitor: every word read but not yet handed over is lost on clr or reset
  always @(negedge clk) begin
    logic [DATA_W-1:0] e;
    check("rd_en_while_empty", longint'(rd_en && buf_empty), 0);
    if (rst_n) begin
      check("pipe_depth_le_2", longint'((reads - delivered) <= 2), 1);
      if (!out_valid) check("last_without_valid", longint'(out_last), 0);
      if (prev_stall) begin
        check("stall_valid", longint'(out_valid), 1);
        check("stall_data", longint'(out_data), longint'(prev_data));
        check("stall_last", longint'(out_last), longint'(prev_last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", longint'(out_data), -1);
        end else begin
          e = exp_q.pop_front();
          check("out_data", longint'(out_data), longint'(e));
          check("out_last", longint'(out_last),
                longint'((since_clr % BURST_LEN) == BURST_LEN - 1));
        end
        delivered++;
        since_clr++;
      end
      prev_stall = out_valid && !out_ready && !clr;
      prev_data  = out_data;
      prev_last  = out_last;
      if (clr) begin
        repeat (reads - delivered) if (exp_q.size() > 0) void'(exp_q.pop_front());
        delivered = reads;
        since_clr = 0;
      end
    end else begin
      repeat (reads - delivered) if (exp_q.size() > 0) void'(exp_q.pop_front());
      delivered  = reads;
      since_clr  = 0;
      prev_stall = 1'b0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_words(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_q.push_back(DATA_W'(base + i));
      exp_q.push_back(DATA_W'(base + i));
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int bound);
    int n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0 || wr_q.size() != 0) && n < bound) begin
      tick();
      n++;
    end
    check(name, longint'(exp_q.size()), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_pulses, c_empty_fall, c_valid_rise, first_c, last_c, nwords, r0;

    // Reset values
    tick(2);
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_out_data", longint'(out_data), 0);
    check("reset_out_last", longint'(out_last), 0);
    check("reset_rd_en", longint'(rd_en), 0);
    rst_n = 1'b1;
    tick(2);

    // Single word: one read, two-cycle latency, FIFO returns to empty
    out_ready = 1'b1;
    write_words(16'hFFFF, 1);
    rd_pulses = 0; c_empty_fall = -1; c_valid_rise = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rd_en) rd_pulses++;
      if (!buf_empty && c_empty_fall < 0) c_empty_fall = cyc;
      if (out_valid && c_valid_rise < 0) begin
        c_valid_rise = cyc;
        check("single_word_data", longint'(out_data), 16'hFFFF);
      end
    end
    check("single_rd_pulses", rd_pulses, 1);
    check("single_latency", c_valid_rise - c_empty_fall, 2);
    check("single_fifo_empty", longint'(buf_empty), 1);
    tick();

    // 11 words back to back with out_ready held high
    pulse_clr();
    write_words(0, 11);
    nwords = 0; first_c = -1; last_c = -1;
    for (int i = 0; i < 40 && nwords < 11; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        nwords++;
      end
    end
    check("b2b_count", nwords, 11);
    check("b2b_span", last_c - first_c, 10);
    tick();
    wait_drain("b2b_drain", 20);

    // out_ready toggling every cycle
    pulse_clr();
    write_words(0, 11);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      out_ready = ~out_ready;
      tick();
    end
    check("toggle_drain", longint'(exp_q.size()), 0);

    // Full FIFO with a 20-cycle stall: exactly two reads fill the pipe
    out_ready = 1'b0;
    pulse_clr();
    write_words(100, 64);
    r0 = reads;
    tick(20);
    check("stall_reads", reads - r0, 2);
    out_ready = 1'b1;
    wait_drain("full_drain", 200);

    // clr with one word buffered and one in flight
    out_ready = 1'b0;
    pulse_clr();
    write_words(200, 5);
    r0 = reads;
    for (int i = 0; i < 20 && (reads - r0) < 2; i++) tick();
    check("clr_setup_reads", reads - r0, 2);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_valid_low", longint'(out_valid), 0);
    out_ready = 1'b1;
    wait_drain("clr_drain", 40);

    // Asynchronous reset between edges mid-burst
    pulse_clr();
    write_words(300, 20);
    tick(4);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", longint'(out_valid), 0);
    check("arst_out_last", longint'(out_last), 0);
    check("arst_rd_en", longint'(rd_en), 0);
    check("arst_out_data", longint'(out_data), 0);
    tick(2);
    rst_n = 1'b1;
    wait_drain("arst_drain", 60);

    // Random traffic, back-pressure and occasional clr
    for (int i = 0; i < 400; i++) begin
      int n;
      out_ready = ($urandom_range(3) != 0);
      clr = ($urandom_range(39) == 0);
      n = $urandom_range(2);
      if (fifo_q.size() + wr_q.size() + n <= DEPTH)
        for (int k = 0; k < n; k++) write_words(int'($urandom_range(16'hFFFF)), 1);
      tick();
    end
    clr = 1'b0;
    out_ready = 1'b1;
    wait_drain("random_drain", 300);

    tick(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
